// File: rtl/tpu_tile_sequencer_if.sv
// Control/data bus between the tile sequencer and its environment.
// Define TPU_SEQ_PERF_EN to carry the busy/stall cycle counters.
interface tpu_tile_sequencer_if #(
  parameter int ADDRESSSIZE = 10,
  parameter int TILE_BW     = 8
);
  logic                   start;
  logic                   abort;
  logic [TILE_BW-1:0]     num_tiles;
  logic [ADDRESSSIZE-1:0] ub_base;
  logic [ADDRESSSIZE-1:0] res_base;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic                   we_rl;
  logic [ADDRESSSIZE-1:0] ub_address;
  logic                   ub_valid;
  logic                   res_write_enable;
  logic [ADDRESSSIZE-1:0] res_address;
  logic                   busy;
  logic                   done;
`ifdef TPU_SEQ_PERF_EN
  logic [31:0]            perf_cycles;
  logic [31:0]            stall_cycles;
`endif

  modport master (
    input  start, abort, num_tiles, ub_base, res_base, fifo_empty,
    output fifo_read_enable, we_rl, ub_address, ub_valid,
           res_write_enable, res_address, busy, done
`ifdef TPU_SEQ_PERF_EN
    , output perf_cycles, stall_cycles
`endif
  );

  modport slave (
    output start, abort, num_tiles, ub_base, res_base, fifo_empty,
    input  fifo_read_enable, we_rl, ub_address, ub_valid,
           res_write_enable, res_address, busy, done
`ifdef TPU_SEQ_PERF_EN
    , input perf_cycles, stall_cycles
`endif
  );
endinterface

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer FSM: weight pop/reload, UB row streaming, pipeline drain, result write.
// Define TPU_SEQ_PERF_EN to add saturating busy-cycle and FIFO-stall counters.
module tpu_tile_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = 32,
  parameter int PIPE_LAT    = 66,
  parameter int TILE_BW     = 8
) (
  input  logic                clk,
  input  logic                rstn,
  tpu_tile_sequencer_if.master bus
);
  localparam int ROW_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MATRIX_SIZE - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WPOP   = 3'd1;
  localparam logic [2:0] S_WLOAD  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [TILE_BW-1:0]     tile_q, tile_d;
  logic [TILE_BW-1:0]     nt_q, nt_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [DRN_W-1:0]       drain_q, drain_d;
  logic [ADDRESSSIZE-1:0] ub_ptr_q, ub_ptr_d;
  logic [ADDRESSSIZE-1:0] res_ptr_q, res_ptr_d;
  logic                   fin_wait_q, fin_wait_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   we_rl_q, we_rl_d;
  logic                   ub_valid_q, ub_valid_d;
  logic                   res_we_q, res_we_d;
  logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
  logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
  logic                   pop;
  logic                   start_acc;

  assign start_acc = (state_q == S_IDLE) && bus.start && !bus.abort;

  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    nt_d       = nt_q;
    row_d      = row_q;
    drain_d    = drain_q;
    ub_ptr_d   = ub_ptr_q;
    res_ptr_d  = res_ptr_q;
    fin_wait_d = fin_wait_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          nt_d      = bus.num_tiles;
          tile_d    = '0;
          row_d     = '0;
          drain_d   = '0;
          ub_ptr_d  = bus.ub_base;
          res_ptr_d = bus.res_base;
          // An empty job spends one extra FINISH cycle so done lands two cycles after start.
          if (bus.num_tiles == '0) begin
            state_d    = S_FINISH;
            fin_wait_d = 1'b1;
          end else begin
            state_d = S_WPOP;
          end
        end
      end
      S_WPOP: begin
        if (!bus.fifo_empty) begin
          pop     = 1'b1;
          state_d = S_WLOAD;
        end
      end
      S_WLOAD: begin
        row_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        row_d = row_q + ROW_W'(1);
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DRN_W'(1);
        if (drain_q == DRN_LAST) begin
          drain_d = '0;
          row_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        row_d = row_q + ROW_W'(1);
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (tile_q == nt_q - TILE_BW'(1)) begin
            state_d = S_FINISH;
          end else begin
            tile_d  = tile_q + TILE_BW'(1);
            state_d = S_WPOP;
          end
        end
      end
      S_FINISH: begin
        if (fin_wait_q) fin_wait_d = 1'b0;
        else            state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The pop is suppressed on abort so no weight set is consumed by a cancelled job.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      pop        = 1'b0;
      fin_wait_d = 1'b0;
    end
  end

  // Outputs are registered from the next state; the row pointers advance once per issued row.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH) && !fin_wait_d;
    we_rl_d    = (state_d == S_WLOAD);
    ub_valid_d = (state_d == S_STREAM);
    res_we_d   = (state_d == S_WRITE);
    ub_addr_d  = ub_addr_q;
    res_addr_d = res_addr_q;
    if (state_d == S_STREAM) ub_addr_d  = ub_ptr_q;
    if (state_d == S_WRITE)  res_addr_d = res_ptr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      tile_q     <= '0;
      nt_q       <= '0;
      row_q      <= '0;
      drain_q    <= '0;
      ub_ptr_q   <= '0;
      res_ptr_q  <= '0;
      fin_wait_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_rl_q    <= 1'b0;
      ub_valid_q <= 1'b0;
      res_we_q   <= 1'b0;
      ub_addr_q  <= '0;
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      nt_q       <= nt_d;
      row_q      <= row_d;
      drain_q    <= drain_d;
      ub_ptr_q   <= (state_d == S_STREAM) ? ub_ptr_q + ADDRESSSIZE'(1) : ub_ptr_d;
      res_ptr_q  <= (state_d == S_WRITE) ? res_ptr_q + ADDRESSSIZE'(1) : res_ptr_d;
      fin_wait_q <= fin_wait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_rl_q    <= we_rl_d;
      ub_valid_q <= ub_valid_d;
      res_we_q   <= res_we_d;
      ub_addr_q  <= ub_addr_d;
      res_addr_q <= res_addr_d;
    end
  end

  assign bus.fifo_read_enable = pop;
  assign bus.we_rl            = we_rl_q;
  assign bus.ub_address       = ub_addr_q;
  assign bus.ub_valid         = ub_valid_q;
  assign bus.res_write_enable = res_we_q;
  assign bus.res_address      = res_addr_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

`ifdef TPU_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    perf_d  = perf_q;
    stall_d = stall_q;
    if (start_acc) begin
      perf_d  = '0;
      stall_d = '0;
    end else begin
      if (busy_q && (perf_q != '1)) perf_d = perf_q + 32'd1;
      if ((state_q == S_WPOP) && bus.fifo_empty && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q  <= '0;
      stall_q <= '0;
    end else begin
      perf_q  <= perf_d;
      stall_q <= stall_d;
    end
  end

  assign bus.perf_cycles  = perf_q;
  assign bus.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Self-checking bench for tpu_tile_sequencer: per-cycle comparison against a job timeline model.
module tb_tpu_tile_sequencer;
  localparam int AW = 10;
  localparam int MS = 32;
  localparam int PL = 66;
  localparam int TW = 8;
  localparam int TILE_LEN = 2 + MS + PL + MS;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tpu_tile_sequencer_if #(.ADDRESSSIZE(AW), .TILE_BW(TW)) bus ();

  tpu_tile_sequencer #(
    .ADDRESSSIZE(AW), .MATRIX_SIZE(MS), .PIPE_LAT(PL), .TILE_BW(TW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  // word: 25 busy, 24 done, 23 pop, 22 we_rl, 21 ub_valid, 20 res_we, 19:10 ub addr, 9:0 res addr
  logic [25:0] exp_w [0:1023];
  logic [25:0] obs_w [0:1023];
  int exp_done_at;
  int exp_busy;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Timeline model: each tile is pop, reload, MS stream rows, PL drain cycles, MS write rows.
  task automatic build_model(input int n, input int ubb, input int rsb,
                             input int st, input int sl, input int ab);
    int cur, p;
    for (int c = 0; c < 1024; c++) exp_w[c] = '0;
    cur = 1;
    for (int t = 0; t < n; t++) begin
      p = cur + ((t == st) ? sl : 0);
      for (int c = cur; c < p + TILE_LEN; c++) exp_w[c][25] = 1'b1;
      exp_w[p][23]   = 1'b1;
      exp_w[p+1][22] = 1'b1;
      for (int r = 0; r < MS; r++) begin
        exp_w[p+2+r][21]         = 1'b1;
        exp_w[p+2+r][19:10]      = 10'((ubb + t*MS + r) % (1 << AW));
        exp_w[p+2+MS+PL+r][20]   = 1'b1;
        exp_w[p+2+MS+PL+r][9:0]  = 10'((rsb + t*MS + r) % (1 << AW));
      end
      cur = p + TILE_LEN;
    end
    if (n == 0) begin
      exp_w[1][25] = 1'b1;
      cur = 2;
    end
    exp_w[cur][25] = 1'b1;
    exp_w[cur][24] = 1'b1;
    exp_done_at = cur;
    if (ab >= 0) begin
      exp_w[ab][23] = 1'b0;
      for (int c = ab + 1; c < 1024; c++) exp_w[c] = '0;
    end
    exp_busy = 0;
    for (int c = 0; c < 1024; c++) if (exp_w[c][25]) exp_busy++;
  endtask

  // Entered and left at 1 time unit after a rising edge; c=0 is the start cycle.
  task automatic drive_job(input int n, input int ubb, input int rsb, input int lo, input int hi,
                           input int ab, input int again, input int len);
    for (int c = 0; c < len; c++) begin
      bus.start     = (c == 0) || (c == again);
      bus.abort     = (c == ab);
      bus.num_tiles = (c == 0) ? TW'(n) : TW'($urandom);
      bus.ub_base   = (c == 0) ? AW'(ubb) : AW'($urandom);
      bus.res_base  = (c == 0) ? AW'(rsb) : AW'($urandom);
      if (c >= lo && c < hi) bus.fifo_empty = 1'b1;
      else if (exp_w[c][23]) bus.fifo_empty = 1'b0;
      else bus.fifo_empty = 1'($urandom);
      @(negedge clk);
      obs_w[c] = {bus.busy, bus.done, bus.fifo_read_enable, bus.we_rl, bus.ub_valid,
                  bus.res_write_enable, bus.ub_valid ? bus.ub_address : 10'd0,
                  bus.res_write_enable ? bus.res_address : 10'd0};
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 0; bus.abort = 0; bus.num_tiles = '0; bus.ub_base = '0; bus.res_base = '0;
    bus.fifo_empty = 1'b0;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.busy, bus.done, bus.fifo_read_enable, bus.we_rl, bus.ub_valid, bus.res_write_enable,
           bus.ub_address, bus.res_address} !== 26'd0) begin
        bad++;
        $display("FAIL reset_outputs: got busy=%b done=%b pop=%b we=%b ubv=%b rw=%b ua=%h ra=%h want all 0",
                 bus.busy, bus.done, bus.fifo_read_enable, bus.we_rl, bus.ub_valid,
                 bus.res_write_enable, bus.ub_address, bus.res_address);
      end
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    build_model(1, 0, 'h100, -1, 0, -1);
    drive_job(1, 0, 'h100, 0, 0, -1, -1, exp_done_at + 3);
    for (int c = 0; c < exp_done_at + 3; c++) begin
      total++;
      if (obs_w[c] !== exp_w[c]) begin
        bad++; $display("FAIL single cyc=%0d got=%h want=%h", c, obs_w[c], exp_w[c]);
      end
    end
    total++;
    if (bus.ub_address !== 10'h01F || bus.res_address !== 10'h11F) begin
      bad++; $display("FAIL addr_hold: got ua=%h ra=%h want ua=01f ra=11f", bus.ub_address, bus.res_address);
    end
`ifdef TPU_SEQ_PERF_EN
    total++;
    if (bus.perf_cycles !== 32'(exp_busy) || bus.stall_cycles !== 32'd0) begin
      bad++; $display("FAIL perf_single: got perf=%0d stall=%0d want perf=%0d stall=0",
                      bus.perf_cycles, bus.stall_cycles, exp_busy);
    end
`endif
  endtask

  task automatic test_wrap;
    int rsb, pops, wes, dones;
    rsb = int'($urandom_range(1023, 0));
    build_model(3, 'h3F0, rsb, -1, 0, -1);
    drive_job(3, 'h3F0, rsb, 0, 0, -1, -1, exp_done_at + 3);
    pops = 0; wes = 0; dones = 0;
    for (int c = 0; c < exp_done_at + 3; c++) begin
      total++;
      if (obs_w[c] !== exp_w[c]) begin
        bad++; $display("FAIL wrap cyc=%0d got=%h want=%h", c, obs_w[c], exp_w[c]);
      end
      pops += int'(obs_w[c][23]); wes += int'(obs_w[c][22]); dones += int'(obs_w[c][24]);
    end
    total++;
    if (pops !== 3 || wes !== 3 || dones !== 1) begin
      bad++; $display("FAIL wrap_counts: got pops=%0d we=%0d done=%0d want 3 3 1", pops, wes, dones);
    end
  endtask

  task automatic test_stall;
    int lo, done_seen;
    lo = 1 + TILE_LEN;
    build_model(3, 'h40, 'h200, 1, 10, -1);
    drive_job(3, 'h40, 'h200, lo, lo + 10, -1, -1, exp_done_at + 3);
    done_seen = -1;
    for (int c = 0; c < exp_done_at + 3; c++) begin
      total++;
      if (obs_w[c] !== exp_w[c]) begin
        bad++; $display("FAIL stall cyc=%0d got=%h want=%h", c, obs_w[c], exp_w[c]);
      end
      if (obs_w[c][24] && done_seen < 0) done_seen = c;
    end
    total++;
    if (done_seen !== 1 + 3*TILE_LEN + 10) begin
      bad++; $display("FAIL stall_done: got cyc=%0d want %0d", done_seen, 1 + 3*TILE_LEN + 10);
    end
`ifdef TPU_SEQ_PERF_EN
    total++;
    if (bus.stall_cycles !== 32'd10 || bus.perf_cycles !== 32'(exp_busy)) begin
      bad++; $display("FAIL perf_stall: got stall=%0d perf=%0d want stall=10 perf=%0d",
                      bus.stall_cycles, bus.perf_cycles, exp_busy);
    end
`endif
  endtask

  task automatic test_zero;
    build_model(0, 'h10, 'h20, -1, 0, -1);
    drive_job(0, 'h10, 'h20, 0, 0, -1, -1, 6);
    for (int c = 0; c < 6; c++) begin
      total++;
      if (obs_w[c] !== exp_w[c]) begin
        bad++; $display("FAIL zero cyc=%0d got=%h want=%h", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_abort;
    int ubb, rsb;
    ubb = int'($urandom_range(1023, 0));
    rsb = int'($urandom_range(1023, 0));
    build_model(2, ubb, rsb, -1, 0, 50);
    drive_job(2, ubb, rsb, 0, 0, 50, -1, 60);
    for (int c = 0; c < 60; c++) begin
      total++;
      if (obs_w[c] !== exp_w[c]) begin
        bad++; $display("FAIL abort cyc=%0d got=%h want=%h", c, obs_w[c], exp_w[c]);
      end
    end
    ubb = int'($urandom_range(1023, 0));
    build_model(1, ubb, rsb, -1, 0, -1);
    drive_job(1, ubb, rsb, 0, 0, -1, -1, exp_done_at + 3);
    for (int c = 0; c < exp_done_at + 3; c++) begin
      total++;
      if (obs_w[c] !== exp_w[c]) begin
        bad++; $display("FAIL after_abort cyc=%0d got=%h want=%h", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_reset_midjob;
    int ubb, rsb;
    ubb = int'($urandom_range(1023, 0));
    rsb = int'($urandom_range(1023, 0));
    build_model(2, ubb, rsb, -1, 0, -1);
    drive_job(2, ubb, rsb, 0, 0, -1, -1, 20);
    for (int c = 0; c < 20; c++) begin
      total++;
      if (obs_w[c] !== exp_w[c]) begin
        bad++; $display("FAIL pre_reset cyc=%0d got=%h want=%h", c, obs_w[c], exp_w[c]);
      end
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.fifo_read_enable, bus.we_rl, bus.ub_valid, bus.res_write_enable,
         bus.ub_address, bus.res_address} !== 26'd0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b ubv=%b ua=%h ra=%h want all 0",
               bus.busy, bus.ub_valid, bus.ub_address, bus.res_address);
    end
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    build_model(1, ubb, rsb, -1, 0, -1);
    drive_job(1, ubb, rsb, 0, 0, -1, 20, exp_done_at + 3);
    for (int c = 0; c < exp_done_at + 3; c++) begin
      total++;
      if (obs_w[c] !== exp_w[c]) begin
        bad++; $display("FAIL post_reset cyc=%0d got=%h want=%h", c, obs_w[c], exp_w[c]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 3; j++) begin
      int n, ubb, rsb, st, sl, lo, again;
      n   = int'($urandom_range(3, 1));
      ubb = int'($urandom_range(1023, 0));
      rsb = int'($urandom_range(1023, 0));
      st  = int'($urandom_range(n - 1, 0));
      sl  = int'($urandom_range(5, 0));
      lo  = 1 + st*TILE_LEN;
      build_model(n, ubb, rsb, st, sl, -1);
      again = int'($urandom_range(exp_done_at - 1, 1));
      drive_job(n, ubb, rsb, lo, lo + sl, -1, again, exp_done_at + 1);
      for (int c = 0; c < exp_done_at + 1; c++) begin
        total++;
        if (obs_w[c] !== exp_w[c]) begin
          bad++; $display("FAIL b2b job=%0d cyc=%0d got=%h want=%h", j, c, obs_w[c], exp_w[c]);
        end
      end
`ifdef TPU_SEQ_PERF_EN
      total++;
      if (bus.stall_cycles !== 32'(sl) || bus.perf_cycles !== 32'(exp_busy)) begin
        bad++; $display("FAIL perf_b2b job=%0d: got stall=%0d perf=%0d want stall=%0d perf=%0d",
                        j, bus.stall_cycles, bus.perf_cycles, sl, exp_busy);
      end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_stall;
    test_zero;
    test_abort;
    test_reset_midjob;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
